// File: rtl/sram_like_data_slave.sv
// sram_like_data_slave: sram_like data-side responder driving a synchronous single-port RAM
module sram_like_data_slave #(
    parameter int RAM_AW    = 16,
    parameter int RAM_LAT   = 1,
    parameter int MAX_OUT   = 2,
    parameter int ADDR_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic [31:0]       data_rdata,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int WW = ADDR_WAIT > 1 ? $clog2(ADDR_WAIT) : 1;

    if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
        $error("RAM_LAT must be in 1..4");
    end
    if (MAX_OUT < 1 || MAX_OUT > 4) begin : g_bad_out
        $error("MAX_OUT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, STALL, READY} state_t;

    state_t             state, state_nx;
    logic [WW-1:0]      wcnt, wcnt_nx;
    logic [2:0]         cnt;
    logic [RAM_LAT-1:0] vld, wrp;
    logic [3:0]         be;
    logic               fsm_ready, acc;
    logic               unused_addr;

    assign unused_addr = ^{data_addr[31:RAM_AW+2]};

    // the last stall cycle (wcnt == 0) already counts as ready so exactly ADDR_WAIT cycles are inserted
    assign fsm_ready    = ADDR_WAIT == 0 || state == READY || (state == STALL && wcnt == '0);
    assign data_addr_ok = !reset && data_req && fsm_ready && (cnt < 3'(MAX_OUT) || data_data_ok);
    assign acc          = data_req && data_addr_ok;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: if (data_req) begin
                state_nx = STALL;
                wcnt_nx  = WW'(ADDR_WAIT > 0 ? ADDR_WAIT - 1 : 0);
            end
            STALL: if (!data_req) state_nx = IDLE;
                   else if (wcnt == '0) state_nx = acc ? IDLE : READY;
                   else wcnt_nx = wcnt - 1'b1;
            READY: if (acc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (ADDR_WAIT == 0) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
            cnt   <= '0;
            vld   <= '0;
            wrp   <= '0;
        end else begin
            state  <= state_nx;
            wcnt   <= wcnt_nx;
            cnt    <= cnt + 3'(acc && !data_data_ok) - 3'(data_data_ok && !acc);
            vld[0] <= acc;
            wrp[0] <= data_wr;
            for (int i = 1; i < RAM_LAT; i++) begin
                vld[i] <= vld[i-1];
                wrp[i] <= wrp[i-1];
            end
        end
    end

    assign be = data_size == 2'b00 ? 4'b0001 << data_addr[1:0] :
                data_size == 2'b01 && !data_addr[0] ? (data_addr[1] ? 4'b1100 : 4'b0011) :
                data_size == 2'b10 && data_addr[1:0] == 2'b00 ? 4'b1111 : 4'b0000;

    assign ram_en       = acc;
    assign ram_wen      = acc && data_wr ? be : 4'b0000;
    assign ram_addr     = acc ? data_addr[RAM_AW+1:2] : '0;
    assign ram_wdata    = acc ? data_wdata : '0;
    assign data_data_ok = vld[RAM_LAT-1];
    assign data_rdata   = data_data_ok && !wrp[RAM_LAT-1] ? ram_rdata : '0;
endmodule

// File: tb/tb_sram_like_data_slave.sv
// tb_sram_like_data_slave: scoreboard bench over three configurations of sram_like_data_slave
module tb_sram_like_data_slave;
    logic clk = 0, reset = 1;
    logic a_req = 0, b_req = 0, c_req = 0, wr = 0;
    logic [1:0] size = 2'b10;
    logic [31:0] addr = 0, wdata = 0;

    logic a_aok, a_ok, a_en, b_aok, b_ok, b_en, c_aok, c_ok, c_en;
    logic [3:0] a_wen, b_wen, c_wen;
    logic [15:0] a_raddr, b_raddr, c_raddr;
    logic [31:0] a_rdata, a_wdata, a_rram, b_rdata, b_wdata, b_rram, c_rdata, c_wdata, c_rram;
    logic [31:0] bp0, bp1;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] q_a[$], q_b[$], q_c[$];
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    sram_like_data_slave #(.RAM_AW(16), .RAM_LAT(1), .MAX_OUT(2), .ADDR_WAIT(0)) u_a (
        .clk(clk), .reset(reset), .data_req(a_req), .data_wr(wr), .data_size(size),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(a_aok), .data_rdata(a_rdata),
        .data_data_ok(a_ok), .ram_en(a_en), .ram_wen(a_wen), .ram_addr(a_raddr),
        .ram_wdata(a_wdata), .ram_rdata(a_rram));

    sram_like_data_slave #(.RAM_AW(16), .RAM_LAT(3), .MAX_OUT(2), .ADDR_WAIT(0)) u_b (
        .clk(clk), .reset(reset), .data_req(b_req), .data_wr(wr), .data_size(size),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(b_aok), .data_rdata(b_rdata),
        .data_data_ok(b_ok), .ram_en(b_en), .ram_wen(b_wen), .ram_addr(b_raddr),
        .ram_wdata(b_wdata), .ram_rdata(b_rram));

    sram_like_data_slave #(.RAM_AW(16), .RAM_LAT(1), .MAX_OUT(2), .ADDR_WAIT(2)) u_c (
        .clk(clk), .reset(reset), .data_req(c_req), .data_wr(wr), .data_size(size),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(c_aok), .data_rdata(c_rdata),
        .data_data_ok(c_ok), .ram_en(c_en), .ram_wen(c_wen), .ram_addr(c_raddr),
        .ram_wdata(c_wdata), .ram_rdata(c_rram));

    // byte-lane RAM behind u_a, one-cycle read latency
    always @(posedge clk) if (a_en) begin
        for (int b = 0; b < 4; b++) if (a_wen[b]) mem[a_raddr[7:0]][b*8+:8] <= a_wdata[b*8+:8];
        a_rram <= mem[a_raddr[7:0]];
    end

    // three-cycle RAM behind u_b whose data is a tag of the word address
    always @(posedge clk) begin
        bp0 <= {16'hC0DE, b_raddr};
        bp1 <= bp0;
        b_rram <= bp1;
    end

    assign c_rram = 32'h600DF00D;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (a_ok) begin
            if (q_a.size() == 0) chk("a_spurious_ok", 1, 0);
            else chk("a_rdata", a_rdata, q_a.pop_front());
        end
        if (b_ok) begin
            if (q_b.size() == 0) chk("b_spurious_ok", 1, 0);
            else chk("b_rdata", b_rdata, q_b.pop_front());
        end
        if (c_ok) begin
            if (q_c.size() == 0) chk("c_spurious_ok", 1, 0);
            else chk("c_rdata", c_rdata, q_c.pop_front());
        end
    end

    task automatic issue_a(input logic w, input logic [1:0] s, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] ew);
        @(posedge clk); #1;
        a_req = 1; wr = w; size = s; addr = ad; wdata = wd;
        #1;
        chk("a_aok", a_aok, 1);
        chk("a_en", a_en, 1);
        chk("a_wen", a_wen, ew);
        chk("a_raddr", a_raddr, ad[17:2]);
        chk("a_wdata", a_wdata, wd);
        q_a.push_back(w ? 32'h0 : ref_mem[ad[9:2]]);
        if (w) for (int b = 0; b < 4; b++) if (ew[b]) ref_mem[ad[9:2]][b*8+:8] = wd[b*8+:8];
        @(posedge clk); #1;
        a_req = 0;
        chk("a_ok_lat", a_ok, 1);
    endtask

    task automatic c_run();
        @(posedge clk); #1;
        c_req = 1; wr = 0; size = 2'b10; addr = 32'h300;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("c_aok_cyc%0d", c), c_aok, c == 2);
            if (c < 2) chk("c_en_stall", c_en, 0);
            if (c_aok) q_c.push_back(32'h600DF00D);
            @(posedge clk); #1;
            if (c == 2) c_req = 0;
        end
    endtask

    initial begin
        int n;
        #2;
        a_req = 1; b_req = 1; c_req = 1;
        #1;
        chk("rst_a_aok", a_aok, 0);
        chk("rst_a_en", a_en, 0);
        chk("rst_b_ok", b_ok, 0);
        chk("rst_c_aok", c_aok, 0);
        a_req = 0; b_req = 0; c_req = 0;
        @(posedge clk); #1 reset = 0;

        issue_a(1, 2'b10, 32'h100, 32'hDEADBEEF, 4'b1111);
        issue_a(0, 2'b10, 32'h100, 32'h0, 4'b0000);
        issue_a(1, 2'b00, 32'h103, 32'hAB000000, 4'b1000);
        issue_a(1, 2'b01, 32'h102, 32'h12340000, 4'b1100);
        issue_a(0, 2'b10, 32'h100, 32'h0, 4'b0000);
        issue_a(1, 2'b10, 32'h102, 32'hFFFFFFFF, 4'b0000);
        issue_a(1, 2'b01, 32'h101, 32'hFFFFFFFF, 4'b0000);
        issue_a(1, 2'b11, 32'h100, 32'hFFFFFFFF, 4'b0000);
        issue_a(0, 2'b10, 32'h100, 32'h0, 4'b0000);
        chk("a_word_after_misaligned", ref_mem[8'h40], 32'h1234BEEF);
        issue_a(1, 2'b00, 32'h101, 32'h0000CD00, 4'b0010);
        issue_a(0, 2'b10, 32'h100, 32'h0, 4'b0000);

        @(posedge clk); #1;
        b_req = 1; wr = 0; size = 2'b10; addr = 32'h200;
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            #1;
            if (c < 4) chk($sformatf("bp_aok_cyc%0d", c), b_aok, c != 2);
            if (c == 3) chk("bp_ok_cyc3", b_ok, 1);
            if (b_aok) begin
                q_b.push_back({16'hC0DE, addr[17:2]});
                n++;
            end
            @(posedge clk); #1;
            if (n == 4) b_req = 0;
            else if (b_aok) addr = addr + 4;
        end
        b_req = 0;
        chk("bp_accepts", n, 4);
        repeat (6) @(posedge clk);
        chk("bp_drained", q_b.size(), 0);

        @(posedge clk); #1;
        b_req = 1; addr = 32'h240;
        #1;
        chk("rst_flight_acc", b_aok, 1);
        @(posedge clk); #1;
        b_req = 0;
        @(posedge clk); #1;
        reset = 1; b_req = 1;
        #1;
        chk("rst_flight_aok", b_aok, 0);
        chk("rst_flight_en", b_en, 0);
        chk("rst_flight_ok", b_ok, 0);
        chk("rst_flight_raddr", b_raddr, 0);
        chk("rst_flight_wdata", b_wdata, 0);
        chk("rst_flight_rdata", b_rdata, 0);
        q_b.delete();
        repeat (2) @(posedge clk);
        #1 reset = 0; b_req = 0;
        chk("rst_cnt", u_b.cnt, 0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_ok", b_ok, 0);
        end

        c_run();
        @(posedge clk); #1;
        c_req = 1; addr = 32'h304;
        #1 chk("retract_aok0", c_aok, 0);
        @(posedge clk); #1;
        c_req = 0;
        #1 chk("retract_en", c_en, 0);
        @(posedge clk); #1;
        chk("retract_idle", 32'(u_c.state), 0);
        c_run();

        repeat (5) @(posedge clk);
        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);
        chk("q_c_empty", q_c.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sram_like_data_slave.md
Name: sram_like_data_slave

Overview:
- Responder end of the CPU data-side sram_like interface, i.e. the memory side of the handshake the MEM stage drives.
- Accepts requests with data_req/data_addr_ok, converts size plus address into byte enables on a synchronous single-port data RAM, and returns one data_data_ok pulse per accepted request, in order.
- Programmable address-phase stall and a bounded outstanding count let the bench and SoC exercise initiator retry and back-pressure paths.

Parameters:
- RAM_AW, 16: word-address width of the RAM; ram_addr = data_addr[RAM_AW+1:2].
- RAM_LAT, 1: RAM read latency in cycles, legal range 1..4. It is also the request-to-data_ok latency for every transaction.
- MAX_OUT, 2: maximum number of accepted-but-unanswered transactions, legal range 1..4.
- ADDR_WAIT, 0: stall cycles inserted before data_addr_ok for each request; 0 means same-cycle accept.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_req  in  1  request valid from the initiator.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- data_addr  in  32  byte address (physical).
- data_wdata  in  32  write data, already lane-aligned by the initiator.
- data_addr_ok  out  1  request accepted this cycle.
- data_rdata  out  32  read data; valid only while data_data_ok is high.
- data_data_ok  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access enable.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RAM_LAT cycles after ram_en.

Behaviour:
Reset
- Asynchronous assertion of reset clears the stall FSM to IDLE, the outstanding counter to 0, and every pipeline valid bit.
- Under reset all outputs read 0.
- Transactions in flight when reset asserts are dropped: no data_ok is produced for them.

Acceptance
- acc = data_req & data_addr_ok.
- data_addr_ok = data_req & fsm_ready & (cnt < MAX_OUT | data_data_ok).
- Acceptance is a combinational function of the same-cycle inputs and has no registered delay.

Stall FSM (ADDR_WAIT > 0)
- IDLE: if data_req is high, go to STALL and load wcnt = ADDR_WAIT-1.
- STALL: decrement wcnt each cycle while data_req is held. If data_req drops, return to IDLE with no side effects. When wcnt = 0, go to READY.
- READY: fsm_ready = 1. On acc, return to IDLE; otherwise hold READY.
- With ADDR_WAIT = 0, fsm_ready is constantly 1 and the FSM is unused.

RAM issue
- On acc: ram_en = 1 and ram_addr = data_addr[RAM_AW+1:2], both in the same cycle; ram_wdata = data_wdata.
- ram_wen = 0 unless data_wr is set and the access is aligned. Aligned write enables:
  - size 00: 4'b0001 << addr[1:0].
  - size 01, addr[0] = 0: addr[1] ? 4'b1100 : 4'b0011.
  - size 10, addr[1:0] = 0: 4'b1111.
- Misaligned accesses and size 11 are still accepted and completed. They produce ram_wen = 0 and do not modify the RAM.

Completion
- A RAM_LAT-deep shift pipeline carries {valid, wr}.
- data_data_ok is the tail valid bit, so it asserts exactly RAM_LAT cycles after acc.
- data_rdata = ram_rdata when the tail entry is a read; otherwise 0.
- Reads return the full word; the initiator extracts the bytes it needs.
- Responses are strictly in order, with at most one data_ok per cycle.
- Back-to-back accepts are allowed and give back-to-back data_ok.

Outstanding counter
- +1 on acc, -1 on data_ok; unchanged when both occur in the same cycle.
- Never exceeds MAX_OUT and never underflows.

Parameter checks
- An elaboration-time check rejects RAM_LAT outside 1..4 and MAX_OUT outside 1..4.

Test Plan:
- Single write, then read, with ADDR_WAIT = 0 and RAM_LAT = 1.
  - Stimulus: req/wr = 1, size 10, addr 0x100, wdata 0xDEADBEEF; then a read of 0x100.
  - Required: addr_ok in the request cycle with ram_wen = 1111, ram_addr = 0x40; data_ok 1 cycle later; the read returns data_rdata = 0xDEADBEEF.
- Byte and halfword lanes.
  - Stimulus: sb to 0x103 with wdata 0xAB000000; sh to 0x102 with wdata 0x12340000.
  - Required: ram_wen = 1000, then 1100; a later word read returns 0x1234BEEF, given the 0xDEADBEEF preload at 0x100.
- Misaligned store.
  - Stimulus: size 10 to 0x102.
  - Required: accepted, ram_wen = 0000, data_ok after RAM_LAT cycles; the word at 0x100 is unchanged.
- Back-pressure with MAX_OUT = 2 and RAM_LAT = 3.
  - Stimulus: data_req held high for 4 reads.
  - Required: addr_ok in cycles 0 and 1, low in cycle 2, high again in cycle 3 together with the first data_ok; the data_ok sequence is in order.
- Stall and retract with ADDR_WAIT = 2.
  - Stimulus: req held high.
  - Required: addr_ok first asserts in cycle 2.
  - Stimulus: req dropped in cycle 1.
  - Required: no ram_en; the FSM is in IDLE; a fresh req again waits 2 cycles.
- Reset mid-flight with RAM_LAT = 3.
  - Stimulus: assert reset 1 cycle after acc.
  - Required: outputs go to 0 immediately; no data_ok ever appears for the dropped request; cnt = 0 after reset is released.
